// File: rtl/cache_pkg.sv
// Shared geometry helpers, flush sequencer state type and address split
// for the cache way blocks.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } flush_state_t;

   // Tag / index / byte-offset fields of an address, widened to fixed sizes.
   typedef struct packed {
      logic [63:0] tag;
      logic [31:0] ix;
      logic [31:0] off;
   } addr_split_t;

   function automatic int ix_width(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int off_width(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   // A single-word line still needs a one-bit select port.
   function automatic int ws_width(input int line_w);
      return ((line_w / 32) > 1) ? $clog2(line_w / 32) : 1;
   endfunction

   function automatic addr_split_t split_addr(input logic [63:0] addr,
                                              input int sets,
                                              input int line_w);
      addr_split_t r;
      int ow;
      int iw;
      ow    = off_width(line_w);
      iw    = ix_width(sets);
      r.off = 32'(addr & ((64'd1 << ow) - 64'd1));
      r.ix  = 32'((addr >> ow) & ((64'd1 << iw) - 64'd1));
      r.tag = addr >> (ow + iw);
      return r;
   endfunction

endpackage

// File: rtl/cache_flush_fsm.sv
// Flush sequencer: walks every set, offers dirty lines to the write-back
// path and produces clear strobes for the V/D arrays at set cnt.
module cache_flush_fsm
   import cache_pkg::*;
#(
   parameter  int SETS = 8,
   localparam int IX_W = ix_width(SETS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_req,
   input  logic            flush_inv,
   input  logic            set_valid,
   input  logic            set_dirty,
   input  logic            wb_ready,
   output logic [IX_W-1:0] cnt,
   output logic            flush_busy,
   output logic            flush_done,
   output logic            wb_valid,
   output logic            clr_v,
   output logic            clr_d,
   output flush_state_t    state
);

   // Handshake: wb_valid rises only in WB and stays high, with the offered
   // set (cnt) frozen, until an edge where wb_ready is also high; that edge
   // completes the transfer and the sequencer moves on without a bubble.

   logic inv_q;
   logic last_set;
   logic handshake;

   assign last_set  = (cnt == IX_W'(SETS - 1));
   assign handshake = (state == WB) && wb_ready;

   // Clear strobes act on the same edge the sequencer leaves SCAN/WB.
   assign clr_d = handshake;
   assign clr_v = inv_q && (((state == SCAN) && !(set_valid && set_dirty)) || handshake);

   // Sequencer state, set counter, invalidate latch and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         inv_q      <= 1'b0;
         flush_busy <= 1'b0;
         flush_done <= 1'b0;
         wb_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_req) begin
                  state      <= SCAN;
                  cnt        <= '0;
                  inv_q      <= flush_inv;
                  flush_busy <= 1'b1;
               end
            end
            SCAN: begin
               if (set_valid && set_dirty) begin
                  state    <= WB;
                  wb_valid <= 1'b1;
               end else if (last_set) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WB: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  if (last_set) begin
                     state      <= DONE;
                     flush_done <= 1'b1;
                  end else begin
                     state <= SCAN;
                     cnt   <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               flush_done <= 1'b0;
               flush_busy <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               flush_busy <= 1'b0;
               flush_done <= 1'b0;
               wb_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cache_way_flush.sv
// One way of a direct-indexed cache: V/D/tag/line storage, line and
// byte-enabled word writes, address peek, and a flush sequencer.
module cache_way_flush
   import cache_pkg::*;
#(
   parameter  int SETS   = 8,
   parameter  int TAG_W  = 9,
   parameter  int LINE_W = 128,
   parameter  int ADDR_W = 16,
   localparam int IX_W   = ix_width(SETS),
   localparam int WS_W   = ws_width(LINE_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IX_W-1:0]   ix,
   input  logic              d_in,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic [LINE_W-1:0] data_in,
   input  logic              ww,
   input  logic [WS_W-1:0]   ww_sel,
   input  logic [3:0]        ww_be,
   input  logic [31:0]       ww_data,
   output logic              v_out,
   output logic              d_out,
   output logic [TAG_W-1:0]  tag_out,
   output logic [LINE_W-1:0] data_out,
   input  logic [ADDR_W-1:0] peek_address,
   output logic              peek_hit,
   input  logic              flush_req,
   input  logic              flush_inv,
   output logic              flush_busy,
   output logic              flush_done,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [IX_W-1:0]   wb_ix,
   output logic [TAG_W-1:0]  wb_tag,
   output logic [LINE_W-1:0] wb_data,
   output flush_state_t      flush_state
);

   logic [SETS-1:0]   v_q;
   logic [SETS-1:0]   d_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];

   logic [IX_W-1:0]   cnt;
   logic              clr_v;
   logic              clr_d;
   logic              line_wr;
   logic              word_wr;

   addr_split_t       peek_split;
   logic [IX_W-1:0]   peek_ix;
   logic [TAG_W-1:0]  peek_tag;
   logic              unused_peek_bits;

   // Writes are frozen while flushing so the offered line stays stable.
   // A word write needs a valid line and at least one byte enabled.
   assign line_wr = we && !flush_busy;
   assign word_wr = ww && !we && !flush_busy && v_q[ix] && (ww_be != 4'b0000);

   assign peek_split       = split_addr(64'(peek_address), SETS, LINE_W);
   assign peek_ix          = IX_W'(peek_split.ix);
   assign peek_tag         = TAG_W'(peek_split.tag);
   assign unused_peek_bits = ^{peek_split.off, peek_split.ix, peek_split.tag};
   assign peek_hit         = v_q[peek_ix] && (tag_q[peek_ix] == peek_tag);

   assign v_out    = v_q[ix];
   assign d_out    = d_q[ix];
   assign tag_out  = tag_q[ix];
   assign data_out = data_q[ix];

   assign wb_ix    = cnt;
   assign wb_tag   = tag_q[cnt];
   assign wb_data  = data_q[cnt];

   // Valid/dirty bits: reset clears them; flush strobes and writes never overlap.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         if (clr_v) v_q[cnt] <= 1'b0;
         if (clr_d) d_q[cnt] <= 1'b0;
         if (line_wr) begin
            v_q[ix] <= 1'b1;
            d_q[ix] <= d_in;
         end else if (word_wr) begin
            d_q[ix] <= 1'b1;
         end
      end
   end

   // Tag and line storage, no reset; word writes merge enabled bytes only.
   always_ff @(posedge clk) begin
      if (line_wr) begin
         tag_q[ix]  <= tag_in;
         data_q[ix] <= data_in;
      end else if (word_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (ww_be[b]) data_q[ix][int'(ww_sel) * 32 + b * 8 +: 8] <= ww_data[b * 8 +: 8];
         end
      end
   end

   cache_flush_fsm #(
      .SETS (SETS)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .flush_req  (flush_req),
      .flush_inv  (flush_inv),
      .set_valid  (v_q[cnt]),
      .set_dirty  (d_q[cnt]),
      .wb_ready   (wb_ready),
      .cnt        (cnt),
      .flush_busy (flush_busy),
      .flush_done (flush_done),
      .wb_valid   (wb_valid),
      .clr_v      (clr_v),
      .clr_d      (clr_d),
      .state      (flush_state)
   );

endmodule

// File: tb/tb_cache_way_flush.sv
// Bench for cache_way_flush: directed steps plus randomized traffic checked
// against a per-set reference model of valid/dirty/tag/line contents.
module tb_cache_way_flush;
   import cache_pkg::*;

   localparam int SETS   = 8;
   localparam int TAG_W  = 9;
   localparam int LINE_W = 128;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [2:0]        ix;
   logic              d_in;
   logic [TAG_W-1:0]  tag_in;
   logic [LINE_W-1:0] data_in;
   logic              ww;
   logic [1:0]        ww_sel;
   logic [3:0]        ww_be;
   logic [31:0]       ww_data;
   logic              v_out;
   logic              d_out;
   logic [TAG_W-1:0]  tag_out;
   logic [LINE_W-1:0] data_out;
   logic [ADDR_W-1:0] peek_address;
   logic              peek_hit;
   logic              flush_req;
   logic              flush_inv;
   logic              flush_busy;
   logic              flush_done;
   logic              wb_valid;
   logic              wb_ready;
   logic [2:0]        wb_ix;
   logic [TAG_W-1:0]  wb_tag;
   logic [LINE_W-1:0] wb_data;
   flush_state_t      flush_state;

   // Reference model of the way contents.
   logic              mv    [SETS];
   logic              md    [SETS];
   logic [TAG_W-1:0]  mtag  [SETS];
   logic [LINE_W-1:0] mdata [SETS];

   int checks = 0;
   int errors = 0;

   cache_way_flush #(
      .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .ix(ix), .d_in(d_in), .tag_in(tag_in),
      .data_in(data_in), .ww(ww), .ww_sel(ww_sel), .ww_be(ww_be), .ww_data(ww_data),
      .v_out(v_out), .d_out(d_out), .tag_out(tag_out), .data_out(data_out),
      .peek_address(peek_address), .peek_hit(peek_hit), .flush_req(flush_req),
      .flush_inv(flush_inv), .flush_busy(flush_busy), .flush_done(flush_done),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_ix(wb_ix), .wb_tag(wb_tag),
      .wb_data(wb_data), .flush_state(flush_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int s = 0; s < SETS; s++) begin
         mv[s] = 1'b0;
         md[s] = 1'b0;
      end
   endtask

   task automatic line_write(input int s, input logic [TAG_W-1:0] t,
                             input logic [LINE_W-1:0] d, input logic dirty);
      we = 1'b1; ix = 3'(s); tag_in = t; data_in = d; d_in = dirty;
      tick();
      we = 1'b0;
      mv[s] = 1'b1; md[s] = dirty; mtag[s] = t; mdata[s] = d;
   endtask

   task automatic word_write(input int s, input int sel, input logic [3:0] be,
                             input logic [31:0] w);
      ww = 1'b1; ix = 3'(s); ww_sel = 2'(sel); ww_be = be; ww_data = w;
      tick();
      ww = 1'b0;
      if (mv[s] && be != 4'b0000) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mdata[s][(sel * 4 + b) * 8 +: 8] = w[b * 8 +: 8];
         md[s] = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      for (int s = 0; s < SETS; s++) begin
         ix = 3'(s);
         #1;
         chk({tag, "_v"}, 128'(v_out), 128'(mv[s]));
         chk({tag, "_d"}, 128'(d_out), 128'(md[s]));
         if (mv[s]) begin
            chk({tag, "_tag"}, 128'(tag_out), 128'(mtag[s]));
            chk({tag, "_data"}, data_out, mdata[s]);
         end
      end
   endtask

   task automatic peek_chk(input logic [15:0] a);
      int s;
      logic exp_hit;
      s = int'(a[6:4]);
      exp_hit = mv[s] && (mtag[s] == a[15:7]);
      peek_address = a;
      #1;
      chk("peek_hit", 128'(peek_hit), 128'(exp_hit));
   endtask

   task automatic fill_clean();
      for (int s = 0; s < SETS; s++)
         line_write(s, TAG_W'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
   endtask

   // Runs one flush; stalls per write-back drawn from [stall_lo, stall_hi].
   task automatic run_flush(input logic inv, input int stall_lo, input int stall_hi,
                            input bit poke, input bit req_again);
      int exp_q[$];
      int stall;
      int k;
      int exp_cyc;
      int cyc;
      int s;
      bit seen_done;
      for (int i = 0; i < SETS; i++) if (mv[i] && md[i]) exp_q.push_back(i);
      exp_cyc = SETS + 1;
      flush_inv = inv;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      flush_inv = 1'b0;
      k = $urandom_range(stall_lo, stall_hi);
      stall = k;
      cyc = 1;
      seen_done = 1'b0;
      while (!seen_done && cyc < 200) begin
         chk("flush_busy", 128'(flush_busy), 128'(1));
         we = poke && (cyc == 2 || cyc == 4);
         ww = poke && (cyc == 3 || cyc == 5);
         ix = 3'($urandom); d_in = 1'b1; tag_in = TAG_W'($urandom);
         data_in = {$urandom, $urandom, $urandom, $urandom};
         ww_sel = 2'($urandom); ww_be = 4'hF; ww_data = $urandom;
         flush_req = req_again && (cyc == 3);
         if (flush_done) begin
            seen_done = 1'b1;
            chk("done_cycle", 128'(cyc), 128'(exp_cyc));
            chk("wb_all_sent", 128'(exp_q.size()), 128'(0));
         end else if (wb_valid) begin
            s = (exp_q.size() > 0) ? exp_q[0] : -1;
            chk("wb_ix", 128'(int'(wb_ix)), 128'(s));
            if (s >= 0) begin
               chk("wb_tag", 128'(wb_tag), 128'(mtag[s]));
               chk("wb_data", wb_data, mdata[s]);
            end
            if (stall > 0) begin
               wb_ready = 1'b0;
               stall--;
            end else begin
               wb_ready = 1'b1;
               exp_cyc += k + 1;
               if (s >= 0) begin
                  void'(exp_q.pop_front());
                  md[s] = 1'b0;
                  if (inv) mv[s] = 1'b0;
               end
               k = $urandom_range(stall_lo, stall_hi);
               stall = k;
            end
         end else begin
            wb_ready = 1'($urandom_range(0, 1));
         end
         if (!seen_done) begin
            tick();
            cyc++;
         end
      end
      chk("done_seen", 128'(seen_done), 128'(1));
      we = 1'b0; ww = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
      if (inv) for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
      tick();
      chk("busy_after", 128'(flush_busy), 128'(0));
      chk("done_after", 128'(flush_done), 128'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_extra_done", 128'(flush_done), 128'(0));
      end
      check_all("post_flush");
   endtask

   initial begin
      int n;
      logic [LINE_W-1:0] base;
      rst = 1'b1; we = 1'b0; ix = '0; d_in = 1'b0; tag_in = '0; data_in = '0;
      ww = 1'b0; ww_sel = '0; ww_be = '0; ww_data = '0; peek_address = '0;
      flush_req = 1'b0; flush_inv = 1'b0; wb_ready = 1'b0;

      // Reset state
      do_reset();
      chk("rst_busy", 128'(flush_busy), 128'(0));
      chk("rst_done", 128'(flush_done), 128'(0));
      chk("rst_wb_valid", 128'(wb_valid), 128'(0));
      chk("rst_state", 128'(flush_state), 128'(IDLE));
      check_all("rst");

      // Directed line write and peek
      base = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      line_write(3, 9'h1A5, base, 1'b0);
      chk("lw_v", 128'(v_out), 128'(1));
      chk("lw_d", 128'(d_out), 128'(0));
      peek_chk(16'hD2B0);
      peek_address = 16'hD2B0;
      #1;
      chk("peek_known_hit", 128'(peek_hit), 128'(1));
      peek_address = 16'hD330;
      #1;
      chk("peek_tag_miss", 128'(peek_hit), 128'(0));

      // Directed word write, then one to an invalid set
      word_write(3, 2, 4'b0101, 32'hAABBCCDD);
      ix = 3'd3;
      #1;
      chk("ww_data", data_out, 128'h0123_4567_89BB_CDDD_0123_4567_89AB_CDEF);
      chk("ww_d", 128'(d_out), 128'(1));
      word_write(6, 1, 4'b1111, 32'h1234_5678);
      ix = 3'd6;
      #1;
      chk("ww_inv_v", 128'(v_out), 128'(0));
      chk("ww_inv_d", 128'(d_out), 128'(0));
      word_write(3, 0, 4'b0000, 32'hFFFF_FFFF);
      check_all("ww_be0");

      // Simultaneous line and word write: line wins
      ww = 1'b1; ww_sel = 2'd0; ww_be = 4'hF; ww_data = 32'hDEAD_BEEF;
      line_write(0, 9'h055, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
      ix = 3'd0;
      #1;
      chk("lw_wins_data", data_out, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      chk("lw_wins_d", 128'(d_out), 128'(0));

      // Random traffic against the model
      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 2);
         if (n == 0)
            line_write($urandom_range(0, SETS - 1), TAG_W'($urandom),
                       {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
         else if (n == 1)
            word_write($urandom_range(0, SETS - 1), $urandom_range(0, 3),
                       4'($urandom), $urandom);
         else begin
            n = $urandom_range(0, SETS - 1);
            if (mv[n] && $urandom_range(0, 1) == 1)
               peek_chk({mtag[n], 3'(n), 4'($urandom)});
            else
               peek_chk(16'($urandom));
         end
      end
      check_all("rand");

      // Flush, sets 1 and 5 dirty, no invalidate, ready always high
      do_reset();
      fill_clean();
      word_write(1, 0, 4'hF, 32'h0101_0101);
      word_write(5, 3, 4'h3, 32'h0505_0505);
      run_flush(1'b0, 0, 0, 1'b0, 1'b0);

      // Flush with invalidate, set 2 dirty, 4-cycle stall, pokes and re-request
      do_reset();
      fill_clean();
      line_write(2, 9'h0F2, 128'hCAFE_0000_CAFE_1111_CAFE_2222_CAFE_3333, 1'b1);
      run_flush(1'b1, 4, 4, 1'b1, 1'b1);

      // Random contents and stalls
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1)
               line_write($urandom_range(0, SETS - 1), TAG_W'($urandom),
                          {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            else
               word_write($urandom_range(0, SETS - 1), $urandom_range(0, 3),
                          4'($urandom), $urandom);
         end
         run_flush(1'($urandom), 0, 3, 1'b0, 1'b0);
      end

      // Reset in the middle of a write-back of set 4
      do_reset();
      fill_clean();
      line_write(4, 9'h144, 128'hF00D_F00D_F00D_F00D_F00D_F00D_F00D_F00D, 1'b1);
      wb_ready = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      n = 0;
      while (!wb_valid && n < 20) begin
         tick();
         n++;
      end
      chk("rst_wb_reached", 128'(wb_valid), 128'(1));
      chk("rst_wb_ix", 128'(wb_ix), 128'(4));
      rst = 1'b1;
      tick();
      chk("rst_wb_busy", 128'(flush_busy), 128'(0));
      chk("rst_wb_valid_low", 128'(wb_valid), 128'(0));
      rst = 1'b0;
      for (int s = 0; s < SETS; s++) begin
         mv[s] = 1'b0;
         md[s] = 1'b0;
      end
      check_all("rst_wb");
      run_flush(1'b0, 0, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
